fifo10_rr_sched: RTL and testbench

//  Round-robin scheduler for N data-less depth-1 token FIFOs (event queues). Watches each FIFO's

---
 rtl/fifo10_rr_sched_pkg.sv | 14 +
 rtl/fifo10_rr_sched_if.sv | 30 +++
 rtl/fifo10_rr_sched_rr_pick.sv | 35 +++
 rtl/fifo10_rr_sched.sv | 116 +++++++++++
 tb/tb_fifo10_rr_sched.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo10_rr_sched_pkg.sv
// Shared definitions for the round-robin token FIFO scheduler.
// State encodings, grant counter width and the supported FIFO count limit.
package fifo10_rr_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StClear = 2'd2
  } state_e;

  localparam int unsigned GrantCntW = 16;
  localparam int unsigned NMax      = 16;

endpackage

// File: rtl/fifo10_rr_sched_if.sv
// Scheduler bus: FIFO flags/strobes, clear handshake and the grant output channel.
// master = scheduler side, slave = FIFO bank / consumer side.
interface fifo10_rr_sched_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
);
  import fifo10_rr_sched_pkg::*;

  logic                 en;
  logic [N-1:0]         empty_n;
  logic [N-1:0]         deq;
  logic                 clr;
  logic                 clr_req;
  logic                 clr_done;
  logic                 out_valid;
  logic [IDXW-1:0]      out_idx;
  logic                 out_ready;
  logic [GrantCntW-1:0] grant_cnt;

  modport master (
    input  en, empty_n, clr_req, out_ready,
    output deq, clr, clr_done, out_valid, out_idx, grant_cnt
  );

  modport slave (
    output en, empty_n, clr_req, out_ready,
    input  deq, clr, clr_done, out_valid, out_idx, grant_cnt
  );

endinterface

// File: rtl/fifo10_rr_sched_rr_pick.sv
// Combinational round-robin pick: rotate requests by ptr, take the lowest set bit,
// then rotate the index back so the result is an absolute FIFO index.
module fifo10_rr_sched_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [N-1:0]    rot;
  logic [IDXW-1:0] enc;
  logic [IDXW:0]   sum;

  // Doubling the vector makes the right shift a rotation.
  assign rot   = N'({req, req} >> ptr);
  assign found = |req;

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDXW'(i);
    end
  end

  always_comb begin
    sum = {1'b0, enc} + {1'b0, ptr};
    if (sum >= (IDXW + 1)'(N)) sum = sum - (IDXW + 1)'(N);
  end

  assign idx = sum[IDXW-1:0];

endmodule

// File: rtl/fifo10_rr_sched.sv
// Round-robin scheduler over N depth-1 token FIFOs with burst control, a registered
// grant output channel, a 16-bit grant counter and a one-cycle global clear sequence.
module fifo10_rr_sched
  import fifo10_rr_sched_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDXW  = 2,
  parameter int unsigned BURST = 1
) (
  input logic                clk,
  input logic                rst_n,
  fifo10_rr_sched_if.master  bus
);

  state_e               state_q;
  logic [IDXW-1:0]      ptr_q;
  logic [IDXW-1:0]      last_q;
  logic [3:0]           burst_q;
  logic                 out_valid_q;
  logic [IDXW-1:0]      out_idx_q;
  logic [GrantCntW-1:0] grant_cnt_q;
  logic                 clr_done_q;

  logic            found;
  logic [IDXW-1:0] win_idx;
  logic            slot_free;
  logic            grant;
  logic [3:0]      burst_inc;
  logic            stay;
  logic [IDXW-1:0] ptr_rot;
  logic [N-1:0]    deq;

  fifo10_rr_sched_rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .req   (bus.empty_n),
    .ptr   (ptr_q),
    .found (found),
    .idx   (win_idx)
  );

  // A clear request suppresses the grant in the cycle it is seen.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign grant     = (state_q == StRun) && bus.en && !bus.clr_req && slot_free && found;

  assign burst_inc = burst_q + 4'd1;
  assign stay      = (win_idx == last_q) && (32'(burst_inc) < BURST);
  assign ptr_rot   = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    deq = '0;
    if (grant) deq[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      last_q      <= '0;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      grant_cnt_q <= '0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_done_q <= (state_q == StClear);

      if (state_q == StClear) begin
        out_valid_q <= 1'b0;
        ptr_q       <= '0;
        last_q      <= '0;
        burst_q     <= '0;
        grant_cnt_q <= '0;
      end else if (grant) begin
        out_valid_q <= 1'b1;
        out_idx_q   <= win_idx;
        grant_cnt_q <= grant_cnt_q + 1'b1;
        last_q      <= win_idx;
        if (stay) begin
          ptr_q   <= win_idx;
          burst_q <= burst_inc;
        end else begin
          ptr_q   <= ptr_rot;
          burst_q <= '0;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (bus.clr_req) begin
        state_q <= StClear;
      end else begin
        case (state_q)
          StIdle:  if (bus.en) state_q <= StRun;
          StRun:   if (!bus.en) state_q <= StIdle;
          StClear: state_q <= bus.en ? StRun : StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.deq       = deq;
  assign bus.clr       = (state_q == StClear);
  assign bus.clr_done  = clr_done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.grant_cnt = grant_cnt_q;

  // Simulation-time sanity: legal size, at most one strobe, never strobe an empty FIFO.
  dequeue_sane: assert property (@(posedge clk) disable iff (!rst_n)
      (N <= NMax) && $onehot0(deq) && ((deq & ~bus.empty_n) == '0))
    else $warning("fifo10_rr_sched: illegal dequeue strobe %b", deq);

endmodule

// File: tb/tb_fifo10_rr_sched.sv
// Bench for fifo10_rr_sched: a BURST=1 and a BURST=2 instance checked against a
// cycle-level reference model derived from the scheduling rules.
module tb_fifo10_rr_sched;

  localparam int N    = 4;
  localparam int IDXW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fifo10_rr_sched_if #(.N(N), .IDXW(IDXW)) bus_a ();
  fifo10_rr_sched_if #(.N(N), .IDXW(IDXW)) bus_b ();

  fifo10_rr_sched #(.N(N), .IDXW(IDXW), .BURST(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  fifo10_rr_sched #(.N(N), .IDXW(IDXW), .BURST(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  // Stimulus staged for the next cycle (nxt_*) and applied this cycle (in_*).
  logic       nxt_en[2], nxt_rdy[2], nxt_cr[2];
  logic [3:0] nxt_e[2];
  logic       in_en[2], in_rdy[2], in_cr[2];
  logic [3:0] in_e[2];

  // Reference model state.
  bit          m_run[2], m_clearing[2], m_valid[2], m_clr_done[2];
  int          m_ptr[2], m_last[2], m_burst[2], m_idx[2];
  logic [15:0] m_cnt[2];
  int          bmax[2] = '{1, 2};
  logic [3:0]  exp_deq[2];

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit may_grant(input int d);
    return m_run[d] && in_en[d] && !in_cr[d] && (!m_valid[d] || in_rdy[d]);
  endfunction

  task automatic model_reset(input int d);
    m_run[d] = 0; m_clearing[d] = 0; m_valid[d] = 0; m_clr_done[d] = 0;
    m_ptr[d] = 0; m_last[d] = 0; m_burst[d] = 0; m_idx[d] = 0; m_cnt[d] = 16'd0;
  endtask

  task automatic model_comb();
    for (int d = 0; d < 2; d++) begin
      int w;
      w = pick(in_e[d], m_ptr[d]);
      exp_deq[d] = (may_grant(d) && w >= 0) ? 4'(1 << w) : 4'b0000;
    end
  endtask

  task automatic model_update(input int d);
    int w;
    bit g;
    if (!rst_n) begin
      model_reset(d);
      return;
    end
    w = pick(in_e[d], m_ptr[d]);
    g = may_grant(d) && (w >= 0);
    m_clr_done[d] = m_clearing[d];
    if (m_clearing[d]) begin
      m_valid[d] = 0; m_ptr[d] = 0; m_burst[d] = 0; m_last[d] = 0; m_cnt[d] = 16'd0;
    end else if (g) begin
      m_valid[d] = 1;
      m_idx[d]   = w;
      m_cnt[d]   = m_cnt[d] + 16'd1;
      if (w == m_last[d] && m_burst[d] + 1 < bmax[d]) begin
        m_ptr[d]   = w;
        m_burst[d] = m_burst[d] + 1;
      end else begin
        m_ptr[d]   = (w + 1) % N;
        m_burst[d] = 0;
      end
      m_last[d] = w;
    end else if (m_valid[d] && in_rdy[d]) begin
      m_valid[d] = 0;
    end
    // Clear wins; otherwise every state settles to RUN exactly when EN is high.
    m_clearing[d] = in_cr[d];
    m_run[d]      = !in_cr[d] && in_en[d];
  endtask

  task automatic set_a(input logic en, input logic [3:0] e, input logic rdy, input logic cr);
    nxt_en[0] = en; nxt_e[0] = e; nxt_rdy[0] = rdy; nxt_cr[0] = cr;
  endtask

  task automatic set_b(input logic en, input logic [3:0] e, input logic rdy, input logic cr);
    nxt_en[1] = en; nxt_e[1] = e; nxt_rdy[1] = rdy; nxt_cr[1] = cr;
  endtask

  task automatic drive_bus();
    bus_a.en = in_en[0]; bus_a.empty_n = in_e[0]; bus_a.out_ready = in_rdy[0];
    bus_a.clr_req = in_cr[0];
    bus_b.en = in_en[1]; bus_b.empty_n = in_e[1]; bus_b.out_ready = in_rdy[1];
    bus_b.clr_req = in_cr[1];
  endtask

  // Close the current cycle, then apply the staged inputs and settle.
  task automatic advance();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      in_en[d] = nxt_en[d]; in_e[d] = nxt_e[d]; in_rdy[d] = nxt_rdy[d]; in_cr[d] = nxt_cr[d];
    end
    drive_bus();
    #1;
    model_comb();
  endtask

  task automatic test_reset();
    set_a(1'b1, 4'hF, 1'b1, 1'b0);
    set_b(1'b1, 4'hF, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      advance();
      n_checks++;
      if (bus_a.deq !== 4'b0000 || bus_b.deq !== 4'b0000) begin
        n_fail++; $display("FAIL reset_deq c%0d: got %b/%b want 0000", c, bus_a.deq, bus_b.deq);
      end
      n_checks++;
      if (bus_a.out_valid !== 1'b0 || bus_a.grant_cnt !== 16'd0 || bus_a.out_idx !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_out c%0d: got v=%b cnt=%0d idx=%0d want 0/0/0", c,
                 bus_a.out_valid, bus_a.grant_cnt, bus_a.out_idx);
      end
      n_checks++;
      if (bus_a.clr !== 1'b0 || bus_a.clr_done !== 1'b0) begin
        n_fail++; $display("FAIL reset_clr c%0d: got %b/%b want 0/0", c, bus_a.clr, bus_a.clr_done);
      end
    end
    set_a(1'b0, 4'h0, 1'b1, 1'b0);
    set_b(1'b0, 4'h0, 1'b1, 1'b0);
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_fairness();
    set_a(1'b1, 4'h0, 1'b1, 1'b0);
    advance();
    for (int k = 0; k < 5; k++) begin
      set_a(1'b1, 4'hF, 1'b1, 1'b0);
      advance();
      n_checks++;
      if (bus_a.deq !== 4'(1 << (k % 4)) || bus_a.deq !== exp_deq[0]) begin
        n_fail++;
        $display("FAIL fair_deq k%0d: got %b want %b", k, bus_a.deq, 4'(1 << (k % 4)));
      end
      if (k > 0) begin
        n_checks++;
        if (bus_a.out_idx !== 2'((k - 1) % 4)) begin
          n_fail++; $display("FAIL fair_idx k%0d: got %0d want %0d", k, bus_a.out_idx, (k - 1) % 4);
        end
      end
    end
    set_a(1'b1, 4'h0, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.out_idx !== 2'd0 || bus_a.out_valid !== 1'b1 || bus_a.grant_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL fair_end: got idx=%0d v=%b cnt=%0d want 0/1/5", bus_a.out_idx,
               bus_a.out_valid, bus_a.grant_cnt);
    end
  endtask

  task automatic test_sparse_wrap();
    set_a(1'b1, 4'b0010, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.deq !== 4'b0010) begin
      n_fail++; $display("FAIL sparse_prep: got %b want 0010", bus_a.deq);
    end
    set_a(1'b1, 4'b1010, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.deq !== 4'b1000) begin
      n_fail++; $display("FAIL sparse_first: got %b want 1000", bus_a.deq);
    end
    set_a(1'b1, 4'b0010, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.deq !== 4'b0010 || bus_a.out_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL sparse_second: got deq=%b idx=%0d want 0010/3", bus_a.deq, bus_a.out_idx);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      set_a(1'b1, 4'hF, 1'b0, 1'b0);
      advance();
      n_checks++;
      if (bus_a.deq !== 4'b0000 || bus_a.out_idx !== 2'd1 || bus_a.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold c%0d: got deq=%b idx=%0d v=%b want 0000/1/1", c, bus_a.deq,
                 bus_a.out_idx, bus_a.out_valid);
      end
    end
    set_a(1'b1, 4'hF, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.deq !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release: got %b want 0100", bus_a.deq);
    end
    set_a(1'b0, 4'h0, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.out_idx !== 2'd2 || bus_a.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_next: got idx=%0d v=%b want 2/1", bus_a.out_idx, bus_a.out_valid);
    end
  endtask

  task automatic test_burst();
    logic [3:0] want[3] = '{4'b0001, 4'b0001, 4'b0010};
    set_a(1'b0, 4'h0, 1'b1, 1'b0);
    set_b(1'b1, 4'h0, 1'b1, 1'b0);
    advance();
    for (int k = 0; k < 6; k++) begin
      set_b(1'b1, 4'b0011, 1'b1, 1'b0);
      advance();
      n_checks++;
      if (bus_b.deq !== exp_deq[1] || (k < 3 && bus_b.deq !== want[k])) begin
        n_fail++; $display("FAIL burst_deq k%0d: got %b want %b", k, bus_b.deq, exp_deq[1]);
      end
    end
    set_b(1'b0, 4'h0, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_b.grant_cnt !== 16'd6 || bus_b.out_idx !== 2'(m_idx[1])) begin
      n_fail++;
      $display("FAIL burst_end: got cnt=%0d idx=%0d want 6/%0d", bus_b.grant_cnt, bus_b.out_idx,
               m_idx[1]);
    end
  endtask

  task automatic test_clear_wrap();
    int guard;
    set_b(1'b0, 4'h0, 1'b1, 1'b0);
    set_a(1'b1, 4'hF, 1'b0, 1'b0);
    advance();
    advance();
    n_checks++;
    if (bus_a.deq !== exp_deq[0] || bus_a.deq === 4'b0000) begin
      n_fail++; $display("FAIL clr_pregrant: got %b want %b", bus_a.deq, exp_deq[0]);
    end
    advance();
    set_a(1'b1, 4'hF, 1'b0, 1'b1);
    advance();
    n_checks++;
    if (bus_a.deq !== 4'b0000 || bus_a.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL clr_req_cycle: got deq=%b v=%b want 0000/1", bus_a.deq,
                         bus_a.out_valid);
    end
    set_a(1'b1, 4'hF, 1'b0, 1'b0);
    advance();
    n_checks++;
    if (bus_a.clr !== 1'b1 || bus_a.deq !== 4'b0000 || bus_a.clr_done !== 1'b0) begin
      n_fail++; $display("FAIL clr_pulse: got clr=%b deq=%b done=%b want 1/0000/0", bus_a.clr,
                         bus_a.deq, bus_a.clr_done);
    end
    set_a(1'b1, 4'hF, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus_a.clr_done !== 1'b1 || bus_a.clr !== 1'b0 || bus_a.out_valid !== 1'b0 ||
        bus_a.grant_cnt !== 16'd0 || bus_a.deq !== 4'b0001) begin
      n_fail++;
      $display("FAIL clr_done: got done=%b clr=%b v=%b cnt=%0d deq=%b want 1/0/0/0/0001",
               bus_a.clr_done, bus_a.clr, bus_a.out_valid, bus_a.grant_cnt, bus_a.deq);
    end
    advance();
    n_checks++;
    if (bus_a.out_idx !== 2'd0 || bus_a.grant_cnt !== 16'd1 || bus_a.clr_done !== 1'b0) begin
      n_fail++; $display("FAIL clr_after: got idx=%0d cnt=%0d done=%b want 0/1/0", bus_a.out_idx,
                         bus_a.grant_cnt, bus_a.clr_done);
    end
    guard = 0;
    while (m_cnt[0] != 16'hFFFF && guard < 70000) begin
      advance();
      guard++;
    end
    n_checks++;
    if (bus_a.grant_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_top: got %h want ffff (guard %0d)", bus_a.grant_cnt, guard);
    end
    advance();
    n_checks++;
    if (bus_a.grant_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got %h want 0000", bus_a.grant_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0]  o_deq[2];
    logic        o_val[2], o_clr[2], o_done[2];
    logic [1:0]  o_idx[2];
    logic [15:0] o_cnt[2];
    for (int c = 0; c < 500; c++) begin
      set_a(($urandom % 10) != 0, 4'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0);
      set_b(($urandom % 10) != 0, 4'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0);
      advance();
      o_deq[0] = bus_a.deq; o_val[0] = bus_a.out_valid; o_clr[0] = bus_a.clr;
      o_done[0] = bus_a.clr_done; o_idx[0] = bus_a.out_idx; o_cnt[0] = bus_a.grant_cnt;
      o_deq[1] = bus_b.deq; o_val[1] = bus_b.out_valid; o_clr[1] = bus_b.clr;
      o_done[1] = bus_b.clr_done; o_idx[1] = bus_b.out_idx; o_cnt[1] = bus_b.grant_cnt;
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (o_deq[d] !== exp_deq[d]) begin
          n_fail++; $display("FAIL rnd_deq d%0d c%0d: got %b want %b", d, c, o_deq[d], exp_deq[d]);
        end
        n_checks++;
        if (!$onehot0(o_deq[d]) || (o_deq[d] & ~in_e[d]) != 4'b0000) begin
          n_fail++; $display("FAIL rnd_strobe d%0d c%0d: got %b with empty_n %b", d, c, o_deq[d],
                             in_e[d]);
        end
        n_checks++;
        if (o_val[d] !== m_valid[d] || (m_valid[d] && o_idx[d] !== 2'(m_idx[d]))) begin
          n_fail++; $display("FAIL rnd_out d%0d c%0d: got v=%b idx=%0d want %b/%0d", d, c,
                             o_val[d], o_idx[d], m_valid[d], m_idx[d]);
        end
        n_checks++;
        if (o_cnt[d] !== m_cnt[d] || o_clr[d] !== m_clearing[d] || o_done[d] !== m_clr_done[d]) begin
          n_fail++;
          $display("FAIL rnd_misc d%0d c%0d: got cnt=%0d clr=%b done=%b want %0d/%b/%b", d, c,
                   o_cnt[d], o_clr[d], o_done[d], m_cnt[d], m_clearing[d], m_clr_done[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    set_a(1'b1, 4'hF, 1'b1, 1'b0);
    set_b(1'b1, 4'hF, 1'b1, 1'b0);
    advance();
    advance();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_a.deq !== 4'b0000 || bus_b.deq !== 4'b0000 || bus_a.out_valid !== 1'b0 ||
        bus_a.grant_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got deq=%b/%b v=%b cnt=%0d want 0/0/0/0", bus_a.deq, bus_b.deq,
               bus_a.out_valid, bus_a.grant_cnt);
    end
    advance();
    advance();
    n_checks++;
    if (bus_b.deq !== 4'b0000 || bus_b.out_valid !== 1'b0 || bus_b.grant_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset_hold: got deq=%b v=%b cnt=%0d want 0/0/0", bus_b.deq,
                         bus_b.out_valid, bus_b.grant_cnt);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      nxt_en[d] = 1'b0; nxt_e[d] = 4'h0; nxt_rdy[d] = 1'b0; nxt_cr[d] = 1'b0;
      in_en[d] = 1'b0; in_e[d] = 4'h0; in_rdy[d] = 1'b0; in_cr[d] = 1'b0;
      model_reset(d);
    end
    drive_bus();
    test_reset();
    test_fairness();
    test_sparse_wrap();
    test_backpressure();
    test_burst();
    test_clear_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
